seq_detector_param: RTL

Parametrised serial pattern detector: the next generation of the single-pattern fixed FSM detectors in the lab sequence. It samples a 1-bit serial stream under a sample-enable and compares the last `PAT_W` accepted bits against a run-time loadable pattern. It supports overlapping and non-overlapping match modes and emits a one-cycle registered match pulse. A saturating hit counter sits alongside, feeding the board display path.

---
 rtl/seq_det_pkg.sv | 20 ++
 rtl/seq_detector_param_sat_counter.sv | 23 ++
 rtl/seq_detector_param.sv | 79 +++++++
 3 files changed

// File: rtl/seq_det_pkg.sv
// Shared defaults and helpers for the parametrised serial pattern detector.
package seq_det_pkg;

  localparam int         DEF_PAT_W     = 4;
  localparam int         DEF_CNT_W     = 8;
  localparam logic [3:0] DEF_PAT_RESET = 4'b1011;

  // Wide enough to hold a fill level from 0 up to the largest legal pattern length (32).
  localparam int FILL_W = 6;

  // Min-saturating increment of the history fill level.
  function automatic logic [FILL_W-1:0] fill_next(input logic [FILL_W-1:0] fill,
                                                  input logic [FILL_W-1:0] limit);
    if (fill >= limit) begin
      return limit;
    end
    return fill + FILL_W'(1);
  endfunction

endpackage

// File: rtl/seq_detector_param_sat_counter.sv
// Saturating up-counter with a clear that wins over increment.
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] q
);

  // Clear beats increment; once all ones, the count holds instead of wrapping.
  always_ff @(posedge clk) begin
    if (rst) begin
      q <= '0;
    end else if (clr) begin
      q <= '0;
    end else if (inc && (q != '1)) begin
      q <= q + W'(1);
    end
  end

endmodule

// File: rtl/seq_detector_param.sv
// Serial pattern detector with a run-time loadable pattern, overlap mode
// select, a registered match pulse and a saturating hit counter.
module seq_detector_param
  import seq_det_pkg::*;
#(
  parameter int               PAT_W     = DEF_PAT_W,
  parameter int               CNT_W     = DEF_CNT_W,
  parameter logic [PAT_W-1:0] PAT_RESET = PAT_W'(DEF_PAT_RESET)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             in,
  input  logic             overlap,
  input  logic             pat_load,
  input  logic [PAT_W-1:0] pat_in,
  input  logic             cnt_clr,
  output logic             out,
  output logic [CNT_W-1:0] hit_cnt
);

  localparam logic [FILL_W-1:0] FULL = FILL_W'(PAT_W);

  generate
    if ((PAT_W < 2) || (PAT_W > 32)) begin : g_bad_pat_w
      $error("seq_detector_param: PAT_W must lie in 2..32");
    end
  endgenerate

  logic [PAT_W-1:0]  pattern;
  logic [PAT_W-1:0]  hist;
  logic [PAT_W-1:0]  hist_n;
  logic [FILL_W-1:0] fill;
  logic [FILL_W-1:0] fill_n;
  logic              match;

  // Compare against the history including the bit being accepted now, so the
  // pulse appears one edge after the completing bit rather than two.
  always_comb begin
    hist_n = {hist[PAT_W-2:0], in};
    fill_n = fill_next(fill, FULL);
    match  = en && !pat_load && (fill_n == FULL) && (hist_n == pattern);
  end

  // Pattern, history and fill tracking; a load restarts matching from scratch.
  always_ff @(posedge clk) begin
    if (rst) begin
      pattern <= PAT_RESET;
      hist    <= '0;
      fill    <= '0;
      out     <= 1'b0;
    end else if (pat_load) begin
      pattern <= pat_in;
      fill    <= '0;
      out     <= 1'b0;
    end else if (en) begin
      hist <= hist_n;
      out  <= match;
      if (match) begin
        fill <= overlap ? FULL : '0;
      end else begin
        fill <= fill_n;
      end
    end else begin
      out <= 1'b0;
    end
  end

  sat_counter #(
    .W(CNT_W)
  ) u_hit_counter (
    .clk(clk),
    .rst(rst),
    .clr(cnt_clr),
    .inc(match),
    .q  (hit_cnt)
  );

endmodule
